// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, flag bit indices and FSM encoding for alu_exec_ctrl
package cpu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_LDI = 3'b111;

  // Bit positions inside the 4-bit {C,Z,V,S} flags word
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_S = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  // Opcodes whose result comes from the external ALU and which update flags
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - general register file: two async read ports, async debug port, one sync write port
module regfile #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata2,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs_q [NREGS];

  // Storage: cleared on reset, single write port updated on the clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Read ports are plain muxes so a write from the previous edge is visible immediately
  always_comb begin
    rdata1   = regs_q[raddr1];
    rdata2   = regs_q[raddr2];
    dbg_data = regs_q[dbg_addr];
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - two-state instruction sequencer driving an external ALU and a register file
module alu_exec_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [AW-1:0]    instr_rd,
  input  logic [AW-1:0]    instr_rs1,
  input  logic [AW-1:0]    instr_rs2,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_sign,
  output logic [3:0]       flags,
  output logic             done,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_t           state_q;
  logic [2:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       flags_q;
  logic             done_q;

  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic             rf_we;
  logic [WIDTH-1:0] rf_wdata;

  // Writeback happens on the edge that ends EXEC; reserved opcodes never write
  always_comb begin
    rf_we    = (state_q == ST_EXEC) && (is_alu_op(op_q) || (op_q == OP_LDI));
    rf_wdata = (op_q == OP_LDI) ? imm_q : alu_res;
  end

  regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (rf_wdata),
    .raddr1   (instr_rs1),
    .rdata1   (rs1_data),
    .raddr2   (instr_rs2),
    .rdata2   (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Sequencer: latch operands on accept, retire after exactly one EXEC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q    <= instr_op;
            rd_q    <= instr_rd;
            imm_q   <= instr_imm;
            a_q     <= rs1_data;
            b_q     <= rs2_data;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_alu_op(op_q)) begin
            flags_q[FLAG_C] <= alu_carry;
            flags_q[FLAG_Z] <= alu_zero;
            flags_q[FLAG_V] <= alu_overflow;
            flags_q[FLAG_S] <= alu_sign;
          end
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_opcode  = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign flags       = flags_q;
  assign done        = done_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - directed self-checking bench for alu_exec_ctrl with a reference ALU
module tb_alu_exec_ctrl;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_rd;
  logic [1:0] instr_rs1;
  logic [1:0] instr_rs2;
  logic [7:0] instr_imm;
  logic [2:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_res;
  logic       alu_carry;
  logic       alu_zero;
  logic       alu_overflow;
  logic       alu_sign;
  logic [3:0] flags;
  logic       done;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int total = 0;
  int bad   = 0;

  alu_exec_ctrl #(.WIDTH(8), .NREGS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_rd     (instr_rd),
    .instr_rs1    (instr_rs1),
    .instr_rs2    (instr_rs2),
    .instr_imm    (instr_imm),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_res      (alu_res),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_sign     (alu_sign),
    .flags        (flags),
    .done         (done),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: ADD with carry/signed overflow, AND, NOT of operand a
  always_comb begin
    logic [8:0] sum;
    sum          = {1'b0, alu_a} + {1'b0, alu_b};
    alu_res      = 8'h00;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      3'b000: begin
        alu_res      = sum[7:0];
        alu_carry    = sum[8];
        alu_overflow = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
      end
      3'b001:  alu_res = alu_a & alu_b;
      3'b010:  alu_res = ~alu_a;
      default: alu_res = 8'h00;
    endcase
    alu_zero = (alu_res == 8'h00);
    alu_sign = alu_res[7];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, {24'h0, dbg_data}, {24'h0, exp});
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [7:0] imm);
    instr_op    = op;
    instr_rd    = rd;
    instr_rs1   = rs1;
    instr_rs2   = rs2;
    instr_imm   = imm;
    instr_valid = 1'b1;
  endtask

  // Issue from IDLE at a negedge, return at the negedge where done should be high
  task automatic run_one(input string tag, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm);
    issue(op, rd, rs1, rs2, imm);
    @(negedge clk);
    instr_valid = 1'b0;
    check({tag, "_exec_ready"}, {31'h0, instr_ready}, 32'h0);
    @(negedge clk);
    check({tag, "_done"}, {31'h0, done}, 32'h1);
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_op    = 3'b000;
    instr_rd    = 2'd0;
    instr_rs1   = 2'd0;
    instr_rs2   = 2'd0;
    instr_imm   = 8'h00;
    dbg_addr    = 2'd0;

    // Reset held then released
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'h0, instr_ready}, 32'h1);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_flags", {28'h0, flags}, 32'h0);
    check("rst_alu_a", {24'h0, alu_a}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check_reg("rst_reg", 2'(i), 8'h00);
    end

    // Back-to-back with valid held: LDI r1=7F, LDI r2=01, ADD r3=r1+r2
    issue(3'b111, 2'd1, 2'd0, 2'd0, 8'h7F);
    @(negedge clk);
    check("b2b_exec1_done", {31'h0, done}, 32'h0);
    issue(3'b111, 2'd2, 2'd0, 2'd0, 8'h01);
    @(negedge clk);
    check("b2b_ret1_done", {31'h0, done}, 32'h1);
    check("b2b_ret1_ready", {31'h0, instr_ready}, 32'h1);
    check_reg("b2b_r1", 2'd1, 8'h7F);
    @(negedge clk);
    check("b2b_exec2_done", {31'h0, done}, 32'h0);
    issue(3'b000, 2'd3, 2'd1, 2'd2, 8'h00);
    @(negedge clk);
    check("b2b_ret2_done", {31'h0, done}, 32'h1);
    check_reg("b2b_r2", 2'd2, 8'h01);
    @(negedge clk);
    check("b2b_exec3_done", {31'h0, done}, 32'h0);
    check("b2b_alu_op", {29'h0, alu_opcode}, 32'h0);
    check("b2b_alu_a", {24'h0, alu_a}, 32'h7F);
    check("b2b_alu_b", {24'h0, alu_b}, 32'h01);
    instr_valid = 1'b0;
    @(negedge clk);
    check("b2b_ret3_done", {31'h0, done}, 32'h1);
    check_reg("b2b_r3", 2'd3, 8'h80);
    check("b2b_flags", {28'h0, flags}, 32'h3);
    @(negedge clk);
    check("b2b_idle_done", {31'h0, done}, 32'h0);

    // Carry and zero: FF + 01
    run_one("ldi_ff", 3'b111, 2'd0, 2'd0, 2'd0, 8'hFF);
    check("ldi_keeps_flags", {28'h0, flags}, 32'h3);
    run_one("ldi_01", 3'b111, 2'd1, 2'd0, 2'd0, 8'h01);
    run_one("add_wrap", 3'b000, 2'd2, 2'd0, 2'd1, 8'h00);
    check_reg("add_wrap_r2", 2'd2, 8'h00);
    check("add_wrap_flags", {28'h0, flags}, 32'hC);

    // NOT then AND
    run_one("ldi_f0", 3'b111, 2'd0, 2'd0, 2'd0, 8'hF0);
    check("ldi_f0_flags", {28'h0, flags}, 32'hC);
    run_one("not", 3'b010, 2'd1, 2'd0, 2'd0, 8'h00);
    check_reg("not_r1", 2'd1, 8'h0F);
    check("not_flags", {28'h0, flags}, 32'h0);
    run_one("and", 3'b001, 2'd2, 2'd0, 2'd1, 8'h00);
    check_reg("and_r2", 2'd2, 8'h00);
    check("and_flags", {28'h0, flags}, 32'h4);

    // rd equal to both sources reads the old value: r1 = 0F + 0F
    run_one("self_add", 3'b000, 2'd1, 2'd1, 2'd1, 8'h00);
    check_reg("self_add_r1", 2'd1, 8'h1E);
    check("self_add_flags", {28'h0, flags}, 32'h0);

    // Reserved opcode: no write, flags kept, single done pulse
    run_one("ldi_55", 3'b111, 2'd0, 2'd0, 2'd0, 8'h55);
    run_one("resv", 3'b101, 2'd0, 2'd0, 2'd0, 8'hAA);
    check_reg("resv_r0", 2'd0, 8'h55);
    check("resv_flags", {28'h0, flags}, 32'h0);
    @(negedge clk);
    check("resv_done_once", {31'h0, done}, 32'h0);

    // Reset during EXEC of ADD r3 abandons it
    issue(3'b000, 2'd3, 2'd0, 2'd1, 8'h00);
    @(negedge clk);
    instr_valid = 1'b0;
    check("abort_in_exec", {31'h0, instr_ready}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_rst_ready", {31'h0, instr_ready}, 32'h1);
    check("abort_rst_done", {31'h0, done}, 32'h0);
    check("abort_rst_alu_a", {24'h0, alu_a}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_done0", {31'h0, done}, 32'h0);
    check("abort_flags", {28'h0, flags}, 32'h0);
    check_reg("abort_r3", 2'd3, 8'h00);
    check_reg("abort_r0", 2'd0, 8'h00);
    @(negedge clk);
    check("abort_done1", {31'h0, done}, 32'h0);
    check_reg("abort_r3_late", 2'd3, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
